mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Sits between the single-cycle core (top1) and the single-port unified RAM.
//  Serialises instruction fetches and data loads/stores onto the one RAM port.
//  Returns the fetched word with i_ready and the load data with d_ready, so the
//  core stalls its PC and writeback until the access completes.
//  Handles fixed-latency RAM timing with a wait-state counter and a 4-state FSM.
// PARAMETERS
//  ADDR_W   32  address width, byte address, word-aligned (bits [1:0] ignored)
//  DATA_W   32  data word width
//  RAM_LAT  2   RAM read/write latency in cycles, legal range 1..15
// PORTS
//  clk              in   1       system clock, rising edge
//  rst              in   1       asynchronous reset, active-high
//  i_req            in   1       core requests instruction fetch at i_addr
//  i_addr           in   ADDR_W  fetch address (pc)
//  instruction_out  out  DATA_W  fetched instruction, valid while i_ready=1
//  i_ready          out  1       one-cycle pulse: fetch complete
//  memRead          in   1       core requests data load at d_addr
//  memWrite         in   1       core requests data store at d_addr
//  d_addr           in   ADDR_W  data address (aluOut)
//  ramstore         in   DATA_W  store data (regData2)
//  ramload          out  DATA_W  load data, valid while d_ready=1
//  d_ready          out  1       one-cycle pulse: load/store complete
//  ram_addr         out  ADDR_W  RAM address
//  ram_wdata        out  DATA_W  RAM write data
//  ram_ren          out  1       RAM read enable
//  ram_wen          out  1       RAM write enable
//  ram_rdata        in   DATA_W  RAM read data, valid RAM_LAT cycles after ren first high
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, counter=0; every output is 0,
//   including instruction_out and ramload. ram_wen must drop without waiting for clk.
//  FSM states: IDLE, BUSY_D, BUSY_I, DONE.
//  IDLE: at each edge, sample requests in priority order:
//   memWrite, then memRead, then i_req.
//   -> BUSY_D on a data request; latch addr, op and wdata.
//   -> BUSY_I on a fetch request; latch addr.
//   -> otherwise stay in IDLE.
//  memRead and memWrite both high: treated as a store.
//  BUSY_x:
//   - ram_addr and ram_wdata are driven from the latched copies and stay stable.
//   - ram_ren (read) or ram_wen (write) is held high for exactly RAM_LAT cycles.
//   - The counter counts 0..RAM_LAT-1.
//   - At the edge where counter==RAM_LAT-1:
//     - read: capture ram_rdata into ramload (BUSY_D) or instruction_out (BUSY_I);
//     - go to DONE.
//  DONE: hold for one cycle.
//   - i_ready=1 (fetch) or d_ready=1 (load/store); ram_ren=ram_wen=0.
//   - Then go to IDLE unconditionally. Requests seen during DONE are ignored.
//  Latency: request sampled at edge E0; ready is high in the cycle after edge
//   E(RAM_LAT). One dead IDLE cycle follows between transactions.
//  instruction_out and ramload hold their last captured value until the next
//   capture. A store never changes ramload.
//  Inputs changing while BUSY have no effect; the latched copies are used.
//  Counter width: $clog2(RAM_LAT+1); it never wraps beyond RAM_LAT-1.
//  i_ready and d_ready are never both high, and each pulses exactly once per
//   accepted transaction.
//  Reset mid-BUSY aborts the access: no ready pulse, no capture, no further
//   ram_ren/ram_wen after rst is released.
// TESTING
//  1. RAM_LAT=2; i_req=1, i_addr=0x04; RAM returns 0x3E800093 ->
//     ram_ren high for 2 cycles; i_ready high in the 3rd cycle after acceptance;
//     instruction_out=0x3E800093.
//  2. i_req and memRead both high at E0, d_addr=0x200 (RAM 0x0000_1234),
//     i_addr=0x08 (RAM 0x0000_0013) ->
//     d_ready with ramload=0x1234 first; then one IDLE cycle;
//     then i_ready with instruction_out=0x13.
//  3. memWrite=1, d_addr=0x100, ramstore=0xDEADBEEF ->
//     ram_wen high for exactly 2 cycles with ram_addr=0x100 and
//     ram_wdata=0xDEADBEEF; d_ready pulses once; ramload unchanged.
//  4. rst pulsed during the 1st BUSY_I cycle ->
//     all outputs 0 immediately; no i_ready; after release, state is IDLE
//     and the next i_req completes normally.
//  5. i_req held high for 12 cycles, RAM_LAT=2 ->
//     exactly 3 i_ready pulses, at a 4-cycle period; no overlap with d_ready.
//  6. Rerun scenarios 1 and 3 with RAM_LAT=1 and RAM_LAT=4 ->
//     ready lands RAM_LAT+1 cycles after acceptance; enables are high for
//     exactly RAM_LAT cycles.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: serialises core data loads/stores and instruction
// fetches onto one RAM port with a fixed-latency wait-state counter.
//
// state  | meaning
// IDLE   | sample requests (store > load > fetch)
// BUSY_D | data access in flight, enable held for RAM_LAT cycles
// BUSY_I | fetch access in flight, ren held for RAM_LAT cycles
// DONE   | one-cycle ready pulse, requests ignored
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RAM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] instruction_out,
    output logic              i_ready,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] ramstore,
    output logic [DATA_W-1:0] ramload,
    output logic              d_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_ren,
    output logic              ram_wen,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int CNT_W = $clog2(RAM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAM_LAT - 1);

    typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I, DONE} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              is_wr_q, is_wr_d;
    logic              is_fetch_q, is_fetch_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] load_q, load_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            is_wr_q    <= 1'b0;
            is_fetch_q <= 1'b0;
            instr_q    <= '0;
            load_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            is_wr_q    <= is_wr_d;
            is_fetch_q <= is_fetch_d;
            instr_q    <= instr_d;
            load_q     <= load_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        is_wr_d    = is_wr_q;
        is_fetch_d = is_fetch_q;
        instr_d    = instr_q;
        load_d     = load_q;
        ram_addr   = '0;
        ram_wdata  = '0;
        ram_ren    = 1'b0;
        ram_wen    = 1'b0;
        i_ready    = 1'b0;
        d_ready    = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // A simultaneous read+write is treated as a store.
                if (memWrite || memRead) begin
                    state_d    = BUSY_D;
                    addr_d     = d_addr;
                    wdata_d    = ramstore;
                    is_wr_d    = memWrite;
                    is_fetch_d = 1'b0;
                end else if (i_req) begin
                    state_d    = BUSY_I;
                    addr_d     = i_addr;
                    is_wr_d    = 1'b0;
                    is_fetch_d = 1'b1;
                end
            end
            BUSY_D, BUSY_I: begin
                ram_addr  = addr_q;
                ram_wdata = wdata_q;
                ram_ren   = !is_wr_q;
                ram_wen   = is_wr_q;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    if (!is_wr_q) begin
                        if (state_q == BUSY_I) instr_d = ram_rdata;
                        else                   load_d  = ram_rdata;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                i_ready = is_fetch_q;
                d_ready = !is_fetch_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign instruction_out = instr_q;
    assign ramload         = load_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (RAM_LAT 1, 2, 4) share the request
// inputs; a transaction-level model predicts every output each cycle.
module tb_mem_arbiter;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        memRead = 1'b0;
    logic        memWrite = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] ramstore = '0;

    logic [31:0] instr_w [NI];
    logic [31:0] ramload_w [NI];
    logic [31:0] ram_addr_w [NI];
    logic [31:0] ram_wdata_w [NI];
    logic [31:0] ram_rdata_w [NI];
    logic        i_ready_w [NI];
    logic        d_ready_w [NI];
    logic        ren_w [NI];
    logic        wen_w [NI];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
        mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(L)) u_dut (
            .clk(clk), .rst(rst),
            .i_req(i_req), .i_addr(i_addr),
            .instruction_out(instr_w[g]), .i_ready(i_ready_w[g]),
            .memRead(memRead), .memWrite(memWrite),
            .d_addr(d_addr), .ramstore(ramstore),
            .ramload(ramload_w[g]), .d_ready(d_ready_w[g]),
            .ram_addr(ram_addr_w[g]), .ram_wdata(ram_wdata_w[g]),
            .ram_ren(ren_w[g]), .ram_wen(wen_w[g]),
            .ram_rdata(ram_rdata_w[g])
        );
    end

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 2 : 4);
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        case (w)
            32'h0000_0004: return 32'h3E80_0093;
            32'h0000_0008: return 32'h0000_0013;
            32'h0000_0200: return 32'h0000_1234;
            default:       return {w[15:0] ^ 16'hA5A5, w[15:0]};
        endcase
    endfunction

    // RAM: data is only valid in the last cycle of an RAM_LAT-long read.
    int ren_cnt [NI];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NI; i++) ren_cnt[i] <= 0;
        end else begin
            for (int i = 0; i < NI; i++) ren_cnt[i] <= ren_w[i] ? ren_cnt[i] + 1 : 0;
        end
    end
    always_comb begin
        for (int i = 0; i < NI; i++) begin
            ram_rdata_w[i] = 32'hBAD0_BAD0;
            if (ren_w[i] && ren_cnt[i] == lat_of(i) - 1) ram_rdata_w[i] = mem_word(ram_addr_w[i]);
        end
    end

    // Transaction model: cycles of access left, a pending ready, last results.
    int          m_left [NI];
    bit          m_done [NI];
    int          m_kind [NI];   // 0 fetch, 1 load, 2 store
    logic [31:0] m_addr [NI];
    logic [31:0] m_wdata [NI];
    logic [31:0] m_instr [NI];
    logic [31:0] m_load [NI];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NI; i++) begin
                m_left[i] <= 0;  m_done[i] <= 1'b0; m_kind[i] <= 0;
                m_addr[i] <= '0; m_wdata[i] <= '0;
                m_instr[i] <= '0; m_load[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                if (m_done[i]) begin
                    m_done[i] <= 1'b0;
                end else if (m_left[i] > 0) begin
                    m_left[i] <= m_left[i] - 1;
                    if (m_left[i] == 1) begin
                        m_done[i] <= 1'b1;
                        if (m_kind[i] == 0) m_instr[i] <= mem_word(m_addr[i]);
                        if (m_kind[i] == 1) m_load[i]  <= mem_word(m_addr[i]);
                    end
                end else if (memWrite) begin
                    m_kind[i] <= 2; m_addr[i] <= d_addr; m_wdata[i] <= ramstore; m_left[i] <= lat_of(i);
                end else if (memRead) begin
                    m_kind[i] <= 1; m_addr[i] <= d_addr; m_left[i] <= lat_of(i);
                end else if (i_req) begin
                    m_kind[i] <= 0; m_addr[i] <= i_addr; m_left[i] <= lat_of(i);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    // Advance to the next falling edge and check every instance against the model.
    task automatic step();
        @(negedge clk);
        cyc++;
        for (int i = 0; i < NI; i++) begin
            logic busy, e_ren, e_wen, e_ir, e_dr, ok;
            logic [31:0] e_addr;
            busy   = m_left[i] > 0;
            e_ren  = busy && m_kind[i] != 2;
            e_wen  = busy && m_kind[i] == 2;
            e_ir   = m_done[i] && m_kind[i] == 0;
            e_dr   = m_done[i] && m_kind[i] != 0;
            e_addr = busy ? m_addr[i] : 32'h0;
            ok = (ren_w[i] === e_ren) && (wen_w[i] === e_wen) &&
                 (i_ready_w[i] === e_ir) && (d_ready_w[i] === e_dr) &&
                 (ram_addr_w[i] === e_addr) && (instr_w[i] === m_instr[i]) &&
                 (ramload_w[i] === m_load[i]) && (!e_wen || ram_wdata_w[i] === m_wdata[i]);
            n_vec++;
            if (!ok) begin
                n_err++;
                $display("FAIL model cyc%0d lat%0d: ren=%b wen=%b ir=%b dr=%b addr=%h wd=%h io=%h rl=%h; want ren=%b wen=%b ir=%b dr=%b addr=%h wd=%h io=%h rl=%h",
                         cyc, lat_of(i), ren_w[i], wen_w[i], i_ready_w[i], d_ready_w[i], ram_addr_w[i],
                         ram_wdata_w[i], instr_w[i], ramload_w[i], e_ren, e_wen, e_ir, e_dr, e_addr,
                         m_wdata[i], m_instr[i], m_load[i]);
            end
        end
    endtask

    // One fetch or store issued for a single edge; measures ready cycle and enable length.
    task automatic measure(input bit is_store, input logic [31:0] addr, input logic [31:0] wd);
        int rdy_at [NI];
        int en_cnt [NI];
        int pulses [NI];
        int bad [NI];
        int exp_rdy [NI];
        exp_rdy = '{2, 3, 5};
        for (int i = 0; i < NI; i++) begin
            rdy_at[i] = -1; en_cnt[i] = 0; pulses[i] = 0; bad[i] = 0;
        end
        if (is_store) begin memWrite = 1'b1; d_addr = addr; ramstore = wd; end
        else begin i_req = 1'b1; i_addr = addr; end
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c == 1) begin
                i_req = 1'b0; memWrite = 1'b0;
                d_addr = 32'hFFFF_FFF0; i_addr = 32'hFFFF_FFF0; ramstore = 32'h0;
            end
            for (int i = 0; i < NI; i++) begin
                if (is_store ? wen_w[i] : ren_w[i]) begin
                    en_cnt[i]++;
                    if (ram_addr_w[i] !== addr || (is_store && ram_wdata_w[i] !== wd)) bad[i]++;
                end
                if (is_store ? d_ready_w[i] : i_ready_w[i]) begin
                    pulses[i]++;
                    if (rdy_at[i] < 0) rdy_at[i] = c;
                end
            end
        end
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("%s lat%0d ready cycle", is_store ? "store" : "fetch", lat_of(i)), rdy_at[i], exp_rdy[i]);
            chk($sformatf("%s lat%0d enable cycles", is_store ? "store" : "fetch", lat_of(i)), en_cnt[i], lat_of(i));
            chk($sformatf("%s lat%0d pulses", is_store ? "store" : "fetch", lat_of(i)), pulses[i], 1);
            chk($sformatf("%s lat%0d addr/wdata drift", is_store ? "store" : "fetch", lat_of(i)), bad[i], 0);
        end
    endtask

    initial begin
        int d_at [NI];
        int i_at [NI];
        int cnt [NI];
        int last [NI];
        int gap_bad [NI];
        int exp_d [NI];
        int exp_i [NI];
        int exp_n [NI];
        exp_d = '{2, 3, 5};
        exp_i = '{5, 7, 11};
        exp_n = '{4, 3, 2};

        step();
        step();
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("reset lat%0d ren/wen/rdy", lat_of(i)),
                {28'h0, ren_w[i], wen_w[i], i_ready_w[i], d_ready_w[i]}, 32'h0);
            chk($sformatf("reset lat%0d ram_addr", lat_of(i)), ram_addr_w[i], 32'h0);
            chk($sformatf("reset lat%0d ram_wdata", lat_of(i)), ram_wdata_w[i], 32'h0);
            chk($sformatf("reset lat%0d instruction_out", lat_of(i)), instr_w[i], 32'h0);
        end
        rst = 1'b0;
        step();

        // Scenario 1 / 6: fetch at 0x04.
        measure(1'b0, 32'h0000_0004, 32'h0);
        for (int i = 0; i < NI; i++)
            chk($sformatf("fetch lat%0d instruction_out", lat_of(i)), instr_w[i], 32'h3E80_0093);

        // Scenario 2: load and fetch together, load wins.
        memRead = 1'b1; d_addr = 32'h0000_0200; i_req = 1'b1; i_addr = 32'h0000_0008;
        for (int i = 0; i < NI; i++) begin d_at[i] = -1; i_at[i] = -1; end
        for (int c = 1; c <= 14; c++) begin
            step();
            if (c == 1) memRead = 1'b0;
            if (c == 7) i_req = 1'b0;
            for (int i = 0; i < NI; i++) begin
                if (d_ready_w[i] && d_at[i] < 0) begin
                    d_at[i] = c;
                    chk($sformatf("prio lat%0d ramload", lat_of(i)), ramload_w[i], 32'h0000_1234);
                end
                if (i_ready_w[i] && i_at[i] < 0) begin
                    i_at[i] = c;
                    chk($sformatf("prio lat%0d instruction_out", lat_of(i)), instr_w[i], 32'h0000_0013);
                end
            end
        end
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("prio lat%0d d_ready cycle", lat_of(i)), d_at[i], exp_d[i]);
            chk($sformatf("prio lat%0d i_ready cycle", lat_of(i)), i_at[i], exp_i[i]);
        end

        // Scenario 3 / 6: store, ramload must keep the earlier load.
        measure(1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
        for (int i = 0; i < NI; i++)
            chk($sformatf("store lat%0d ramload kept", lat_of(i)), ramload_w[i], 32'h0000_1234);

        // Read and write together behave as a store.
        memRead = 1'b1; memWrite = 1'b1; d_addr = 32'h0000_0300; ramstore = 32'hCAFE_F00D;
        step();
        memRead = 1'b0; memWrite = 1'b0;
        chk("rd+wr lat2 wen/ren", {30'h0, wen_w[1], ren_w[1]}, 32'h2);
        chk("rd+wr lat2 wdata", ram_wdata_w[1], 32'hCAFE_F00D);
        for (int c = 0; c < 8; c++) step();

        // Scenario 4: reset in the first BUSY_I cycle.
        i_req = 1'b1; i_addr = 32'h0000_000C;
        step();
        i_req = 1'b0;
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("midrst lat%0d ren/wen/rdy", lat_of(i)),
                {28'h0, ren_w[i], wen_w[i], i_ready_w[i], d_ready_w[i]}, 32'h0);
            chk($sformatf("midrst lat%0d outputs", lat_of(i)),
                ram_addr_w[i] | instr_w[i] | ramload_w[i] | ram_wdata_w[i], 32'h0);
        end
        step();
        #2 rst = 1'b0;
        for (int i = 0; i < NI; i++) cnt[i] = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            for (int i = 0; i < NI; i++)
                if (i_ready_w[i] || ren_w[i] || wen_w[i] || d_ready_w[i]) cnt[i]++;
        end
        for (int i = 0; i < NI; i++)
            chk($sformatf("postrst lat%0d activity", lat_of(i)), cnt[i], 0);
        measure(1'b0, 32'h0000_0004, 32'h0);

        // Scenario 5: i_req held for 12 edges.
        i_req = 1'b1; i_addr = 32'h0000_0010;
        for (int i = 0; i < NI; i++) begin cnt[i] = 0; last[i] = -1; gap_bad[i] = 0; d_at[i] = 0; end
        for (int c = 1; c <= 20; c++) begin
            step();
            if (c == 12) i_req = 1'b0;
            for (int i = 0; i < NI; i++) begin
                if (d_ready_w[i]) d_at[i]++;
                if (i_ready_w[i]) begin
                    cnt[i]++;
                    if (last[i] >= 0 && c - last[i] != lat_of(i) + 2) gap_bad[i]++;
                    last[i] = c;
                end
            end
        end
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("stream lat%0d i_ready count", lat_of(i)), cnt[i], exp_n[i]);
            chk($sformatf("stream lat%0d period errors", lat_of(i)), gap_bad[i], 0);
            chk($sformatf("stream lat%0d d_ready count", lat_of(i)), d_at[i], 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
